serial_pattern_gen: RTL and testbench
=====================================

# serial_pattern_gen

Serial pattern generator. Captures an up-to-PAT_W-bit pattern on a start pulse and shifts it out MSB-first on a single-bit `dout` line, one bit per clock, for a programmable number of repetitions with programmable idle gaps between them. It is the transmit-side companion of the team's serial pattern-detector FSMs. It drives their `din` directly in the datapath and in bench loop-back.

## Interface
Parameters:
- PAT_W, 8, maximum pattern length in bits.
- LEN_W, 4, width of `pat_len`; must satisfy 2^LEN_W > PAT_W.
- CNT_W, 4, width of `rep_cnt` and `gap_len`.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- pattern  input  PAT_W  pattern bits; the transmitted field is `pattern[pat_len-1:0]`.
- pat_len  input  LEN_W  number of bits to send per repetition.
- rep_cnt  input  CNT_W  extra repetitions; total transmissions = rep_cnt+1.
- gap_len  input  CNT_W  idle cycles inserted between repetitions.
- dout  output  1  serial data.
- dout_valid  output  1  high while `dout` carries a pattern bit.
- frame_start  output  1  high during the first bit of each repetition.
- busy  output  1  high in SEND and GAP.
- done  output  1  one-cycle pulse at completion.

## Operation
- States: IDLE, SEND, GAP, DONE. All outputs come from registers or decode of registered state only, with no combinational path from inputs.
- Reset: state=IDLE; dout=0, dout_valid=0, frame_start=0, busy=0, done=0. All counters and shadow registers clear to 0. Reset asserted mid-operation aborts immediately. No done pulse is generated for the aborted operation.
- IDLE: outputs low. On an edge with start=1:
  - latch `pattern`, `gap_len` and `rep_cnt` into shadow registers; inputs are don't-care after that edge.
  - latch `pat_len` into the length register, clamping any value above PAT_W to PAT_W.
  - load bit index = len-1.
  - if len==0, go to DONE; otherwise go to SEND.
- SEND:
  - dout = shadow[bit index]; dout_valid=1; busy=1.
  - frame_start=1 when bit index = len-1.
  - Each cycle, decrement the bit index.
  - On the cycle with bit index 0 and remaining reps > 0: decrement reps and reload bit index = len-1. Then go to GAP if gap_len > 0; otherwise stay in SEND, so the next repetition follows back-to-back with no bubble.
  - On the cycle with bit index 0 and reps == 0: go to DONE.
- GAP: dout=0; dout_valid=0; busy=1. Count gap_len cycles, then return to SEND.
- DONE: one cycle with done=1 and busy=0, then go to IDLE.
- start is ignored in SEND, GAP and DONE; no queuing.
- Counter arithmetic is unsigned. The bit index is LEN_W wide, and reps and gap counters are CNT_W wide. Counters never wrap, because reloads happen at 0.

## Timing
- Capture edge E0 (start=1 in IDLE). The first bit is on `dout` in the cycle after E0, so latency is 1 cycle.
- A single repetition occupies cycles 1..len. done=1 in cycle len+1, and IDLE is entered in cycle len+2. start is first accepted at the edge ending cycle len+2.
- busy spans (rep_cnt+1)·len + rep_cnt·gap_len cycles.
- The last repetition is never followed by a gap.
- len==0: done=1 in cycle 1 after E0; dout_valid never asserts.
- dout changes only on clk edges, so the output is glitch-free for a downstream detector.
- With reset deasserted asynchronously, the first accepted start is at the first edge after deassertion.

## Test plan
- Single repetition: pattern=8'b00000101, pat_len=3, rep_cnt=0, gap_len=0, start for 1 cycle.
  - dout=1,0,1 with dout_valid=1 for 3 cycles; frame_start only in cycle 1.
  - done=1 in cycle 4; busy high for cycles 1-3.
  - Loop-back into the 3-bit "101" detector: it flags once.
- Repetitions with gap: pattern=8'hA5, pat_len=8, rep_cnt=2, gap_len=2.
  - Three 10100101 bursts, each separated by 2 cycles of dout_valid=0, dout=0.
  - busy for 28 cycles; done in cycle 29; frame_start pulses 3 times.
- Back-to-back repetitions: pattern=8'b00000110, pat_len=3, rep_cnt=3, gap_len=0.
  - dout_valid continuously high for 12 cycles with stream 110110110110; done in cycle 13.
- Boundary lengths:
  - pat_len=0: done in cycle 1, no dout_valid.
  - pat_len=15 with PAT_W=8: 8 bits sent, identical to pat_len=8.
- Start ignored while busy:
  - Pulse start with different inputs during SEND, GAP and DONE: no effect on the output stream.
  - After done, a new start is accepted and its new pattern is transmitted.
- Reset mid-operation: assert reset during bit 4 of an 8-bit send.
  - All outputs 0 immediately, with no done pulse.
  - After release, a fresh start transmits the full pattern from bit len-1.

Source files
------------

// File: rtl/serial_pattern_gen.sv
// rtl/serial_pattern_gen.sv - MSB-first serial pattern generator with repeats and gaps
module serial_pattern_gen #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [CNT_W-1:0] gap_len,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PAT_W-1:0] PAT_ONE = PAT_W'(1);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [CNT_W-1:0] gap_len_q, gap_len_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;

  // Requested length, clamped to the widest pattern the shadow register holds.
  logic [LEN_W-1:0] len_in;
  assign len_in = (pat_len > LEN_MAX) ? LEN_MAX : pat_len;

  // State and shadow registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      reps_q    <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      reps_q    <= reps_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Next-state logic and output decode from registered state only.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    idx_d       = idx_q;
    reps_d      = reps_q;
    gap_len_d   = gap_len_q;
    gap_cnt_d   = gap_cnt_q;
    dout        = 1'b0;
    dout_valid  = 1'b0;
    frame_start = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d     = pattern;
          gap_len_d = gap_len;
          reps_d    = rep_cnt;
          len_d     = len_in;
          gap_cnt_d = '0;
          if (len_in == '0) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d   = len_in - LEN_ONE;
            state_d = S_SEND;
          end
        end
      end

      S_SEND: begin
        dout        = |(pat_q & (PAT_ONE << idx_q));
        dout_valid  = 1'b1;
        busy        = 1'b1;
        frame_start = (idx_q == len_q - LEN_ONE);
        if (idx_q == '0) begin
          if (reps_q != '0) begin
            reps_d = reps_q - CNT_ONE;
            idx_d  = len_q - LEN_ONE;
            if (gap_len_q != '0) begin
              gap_cnt_d = gap_len_q - CNT_ONE;
              state_d   = S_GAP;
            end
          end else begin
            state_d = S_DONE;
          end
        end else begin
          idx_d = idx_q - LEN_ONE;
        end
      end

      S_GAP: begin
        busy = 1'b1;
        if (gap_cnt_q == '0) begin
          state_d = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_ONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb/tb_serial_pattern_gen.sv - randomized self-checking bench for serial_pattern_gen
module tb_serial_pattern_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] pat_len;
  logic [3:0] rep_cnt;
  logic [3:0] gap_len;
  logic       dout;
  logic       dout_valid;
  logic       frame_start;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Per-cycle output record: {dout, dout_valid, frame_start, busy, done}
  logic [4:0] exp_q[$];
  logic [4:0] obs_q[$];

  serial_pattern_gen #(.PAT_W(8), .LEN_W(4), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .pat_len    (pat_len),
    .rep_cnt    (rep_cnt),
    .gap_len    (gap_len),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_start(frame_start),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-cycle outputs from cycle 1 after the capture edge through the first idle cycle.
  function automatic void model(input logic [7:0] pat, input int plen, input int rep, input int gap);
    int len;
    len = (plen > 8) ? 8 : plen;
    exp_q.delete();
    if (len > 0) begin
      for (int r = 0; r <= rep; r++) begin
        for (int b = len - 1; b >= 0; b--)
          exp_q.push_back({pat[b], 1'b1, (b == len - 1), 1'b1, 1'b0});
        if (r < rep)
          for (int g = 0; g < gap; g++) exp_q.push_back(5'b00010);
      end
    end
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00000);
  endfunction

  // Issue one start and record outputs until one cycle past done (bounded).
  task automatic play(input logic [7:0] pat, input logic [3:0] plen, input logic [3:0] rep,
                      input logic [3:0] gap, input bit noise);
    obs_q.delete();
    @(negedge clk);
    start = 1'b1; pattern = pat; pat_len = plen; rep_cnt = rep; gap_len = gap;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      obs_q.push_back({dout, dout_valid, frame_start, busy, done});
      if (noise) begin
        start   = 1'($urandom_range(1));
        pattern = 8'($urandom);
        pat_len = 4'($urandom);
        rep_cnt = 4'($urandom);
        gap_len = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        @(negedge clk);
        obs_q.push_back({dout, dout_valid, frame_start, busy, done});
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; pattern = '0; pat_len = '0; rep_cnt = '0; gap_len = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dout, dout_valid, frame_start, busy, done} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000", {dout, dout_valid, frame_start, busy, done});
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    logic [2:0] sh;
    int nbits, hits;
    model(8'b00000101, 3, 0, 0);
    play(8'b00000101, 4'd3, 4'd0, 4'd0, 1'b0);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL single_len: got %0d cycles want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL single_cycle%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    sh = '0; nbits = 0; hits = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i][3]) begin
        sh = {sh[1:0], obs_q[i][4]};
        nbits++;
        if (nbits >= 3 && sh == 3'b101) hits++;
      end
    end
    checks++;
    if (hits !== 1) begin
      errors++;
      $display("FAIL single_loopback_101: got %0d hits want 1", hits);
    end
  endtask

  task automatic test_gap;
    int fs, bz;
    model(8'hA5, 8, 2, 2);
    play(8'hA5, 4'd8, 4'd2, 4'd2, 1'b0);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL gap_len: got %0d cycles want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL gap_cycle%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    fs = 0; bz = 0;
    foreach (obs_q[i]) begin
      fs += int'(obs_q[i][2]);
      bz += int'(obs_q[i][1]);
    end
    checks++;
    if (fs !== 3 || bz !== 28) begin
      errors++;
      $display("FAIL gap_counts: got frame_start=%0d busy=%0d want 3 and 28", fs, bz);
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] stream;
    model(8'b00000110, 3, 3, 0);
    play(8'b00000110, 4'd3, 4'd3, 4'd0, 1'b0);
    stream = '0;
    for (int i = 0; i < 12 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i][3] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_valid_cycle%0d: got %b want 1", i + 1, obs_q[i][3]);
      end
      stream = {stream[10:0], obs_q[i][4]};
    end
    checks++;
    if (stream !== 12'b110110110110) begin
      errors++;
      $display("FAIL b2b_stream: got %b want 110110110110", stream);
    end
    checks++;
    if (obs_q.size() < 13 || obs_q[12] !== 5'b00001) begin
      errors++;
      $display("FAIL b2b_done_cycle13: got %0d cycles want done at cycle 13", obs_q.size());
    end
  endtask

  task automatic test_boundary;
    logic [4:0] ref8[$];
    model(8'h3C, 0, 2, 3);
    play(8'h3C, 4'd0, 4'd2, 4'd3, 1'b0);
    checks++;
    if (obs_q.size() !== 2 || obs_q[0] !== 5'b00001 || obs_q[1] !== 5'b00000) begin
      errors++;
      $display("FAIL len0: got %0d cycles first=%b want 2 cycles first=00001", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 5'bxxxxx);
    end
    model(8'h9B, 8, 1, 1);
    play(8'h9B, 4'd8, 4'd1, 4'd1, 1'b0);
    ref8 = obs_q;
    play(8'h9B, 4'd15, 4'd1, 4'd1, 1'b0);
    checks++;
    if (obs_q.size() !== exp_q.size() || ref8.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL len15_size: got %0d/%0d cycles want %0d", obs_q.size(), ref8.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size() && i < ref8.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || ref8[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL len15_cycle%0d: got %b (len8 %b) want %b", i + 1, obs_q[i], ref8[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_ignored;
    model(8'hD2, 6, 2, 3);
    play(8'hD2, 4'd6, 4'd2, 4'd3, 1'b1);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL ignore_len: got %0d cycles want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ignore_cycle%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    model(8'h4E, 7, 0, 0);
    play(8'h4E, 4'd7, 4'd0, 4'd0, 1'b0);
    checks++;
    if (obs_q !== exp_q) begin
      errors++;
      $display("FAIL ignore_next_start: got %0d cycles want %0d, streams differ", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] pat;
    logic       bad;
    pat = 8'hC3;
    @(negedge clk);
    start = 1'b1; pattern = pat; pat_len = 4'd8; rep_cnt = 4'd1; gap_len = 4'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (dout !== pat[7 - i] || dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_bit%0d: got dout=%b valid=%b want dout=%b valid=1", i + 1, dout, dout_valid, pat[7 - i]);
      end
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({dout, dout_valid, frame_start, busy, done} !== 5'b00000) begin
      errors++;
      $display("FAIL rstmid_immediate: got %b want 00000", {dout, dout_valid, frame_start, busy, done});
    end
    bad = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if ({dout, dout_valid, frame_start, busy, done} !== 5'b00000) bad = 1'b1;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_done: got activity after abort want all outputs 0");
    end
    model(8'h6D, 8, 0, 0);
    play(8'h6D, 4'd8, 4'd0, 4'd0, 1'b0);
    checks++;
    if (obs_q !== exp_q) begin
      errors++;
      $display("FAIL rstmid_restart: got %0d cycles want %0d, streams differ", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random;
    logic [7:0] p;
    logic [3:0] l, r, g;
    bit         n;
    for (int t = 0; t < 25; t++) begin
      p = 8'($urandom);
      l = 4'($urandom);
      r = 4'($urandom_range(3));
      g = 4'($urandom_range(3));
      n = 1'($urandom_range(1));
      model(p, int'(l), int'(r), int'(g));
      play(p, l, r, g, n);
      checks++;
      if (obs_q !== exp_q) begin
        errors++;
        $display("FAIL random%0d: pat=%h len=%0d rep=%0d gap=%0d got %0d cycles want %0d, streams differ",
                 t, p, l, r, g, obs_q.size(), exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_back_to_back();
    test_boundary();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
